// File: rtl/sw_affine_pe_if.sv
// Bundles the data, symbol, control and score-configuration signals of one
// Smith-Waterman affine-gap processing element in a systolic array.
interface sw_affine_pe_if #(
    parameter int SCORE_W = 10,
    parameter int SYM_W   = 2,
    parameter int COL_W   = 16
);
    logic signed [SCORE_W-1:0] V_in;
    logic signed [SCORE_W-1:0] F_in;
    logic        [SYM_W-1:0]   T_in;
    logic        [SYM_W-1:0]   S_in;
    logic                      store_S;
    logic                      init_in;
    logic                      cfg_we;
    logic signed [SCORE_W-1:0] cfg_match;
    logic signed [SCORE_W-1:0] cfg_mismatch;
    logic signed [SCORE_W-1:0] cfg_open;
    logic signed [SCORE_W-1:0] cfg_ext;
    logic                      cfg_local;
    logic signed [SCORE_W-1:0] V_out;
    logic signed [SCORE_W-1:0] F_out;
    logic        [SYM_W-1:0]   T_out;
    logic                      init_out;
    logic signed [SCORE_W-1:0] best_score;
    logic        [COL_W-1:0]   best_col;

    modport master (
        output V_in, F_in, T_in, S_in, store_S, init_in,
        output cfg_we, cfg_match, cfg_mismatch, cfg_open, cfg_ext, cfg_local,
        input  V_out, F_out, T_out, init_out, best_score, best_col
    );

    modport slave (
        input  V_in, F_in, T_in, S_in, store_S, init_in,
        input  cfg_we, cfg_match, cfg_mismatch, cfg_open, cfg_ext, cfg_local,
        output V_out, F_out, T_out, init_out, best_score, best_col
    );
endinterface

// File: rtl/sw_affine_pe.sv
// One Smith-Waterman PE with affine gap penalties (Gotoh recurrence), holding one
// query symbol and scoring one reference column per valid cycle, latency 1.
module sw_affine_pe #(
    parameter int SCORE_W      = 10,
    parameter int SYM_W        = 2,
    parameter int COL_W        = 16,
    parameter int MATCH_RST    = 10,
    parameter int MISMATCH_RST = -2,
    parameter int OPEN_RST     = -2,
    parameter int EXT_RST      = -1
) (
    input logic              clk,
    input logic              rst,
    sw_affine_pe_if.slave    bus
);
    localparam logic signed [SCORE_W-1:0] NEG = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic signed [SCORE_W-1:0] POS = {1'b0, {(SCORE_W-1){1'b1}}};

    function automatic logic signed [SCORE_W-1:0] sat_add(
        input logic signed [SCORE_W-1:0] a,
        input logic signed [SCORE_W-1:0] b
    );
        logic [SCORE_W:0] s;
        s = {a[SCORE_W-1], a} + {b[SCORE_W-1], b};
        if (s[SCORE_W] != s[SCORE_W-1]) begin
            return s[SCORE_W] ? NEG : POS;
        end
        return s[SCORE_W-1:0];
    endfunction

    function automatic logic signed [SCORE_W-1:0] smax(
        input logic signed [SCORE_W-1:0] a,
        input logic signed [SCORE_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic signed [SCORE_W-1:0] v_out_q, v_out_d, f_out_q, f_out_d;
    logic        [SYM_W-1:0]   t_out_q, t_out_d, s_q, s_d;
    logic                      init_q, init_d;
    logic signed [SCORE_W-1:0] vdiag_q, vdiag_d, vleft_q, vleft_d, e_q, e_d;
    logic        [COL_W-1:0]   col_q, col_d, bcol_q, bcol_d;
    logic signed [SCORE_W-1:0] best_q, best_d;
    logic signed [SCORE_W-1:0] match_q, match_d, mis_q, mis_d;
    logic signed [SCORE_W-1:0] open_q, open_d, ext_q, ext_d;
    logic                      local_q, local_d;

    logic signed [SCORE_W-1:0] f_new, e_new, sub, v_raw, v_new;

    // Cell recurrence; every add saturates so large scores clip instead of wrapping.
    always_comb begin
        f_new = smax(sat_add(bus.V_in, open_q), sat_add(bus.F_in, ext_q));
        e_new = smax(sat_add(vleft_q, open_q), sat_add(e_q, ext_q));
        sub   = (bus.T_in == s_q) ? match_q : mis_q;
        v_raw = smax(smax(sat_add(vdiag_q, sub), e_new), f_new);
        v_new = (local_q && v_raw[SCORE_W-1]) ? '0 : v_raw;
    end

    always_comb begin
        v_out_d = v_out_q;
        f_out_d = f_out_q;
        t_out_d = t_out_q;
        init_d  = 1'b0;
        s_d     = s_q;
        vdiag_d = vdiag_q;
        vleft_d = vleft_q;
        e_d     = e_q;
        col_d   = col_q;
        best_d  = best_q;
        bcol_d  = bcol_q;
        match_d = match_q;
        mis_d   = mis_q;
        open_d  = open_q;
        ext_d   = ext_q;
        local_d = local_q;

        // A new query symbol starts a fresh row and discards any column offered with it.
        if (bus.store_S) begin
            s_d     = bus.S_in;
            vdiag_d = '0;
            vleft_d = '0;
            e_d     = NEG;
            col_d   = '0;
            best_d  = NEG;
            bcol_d  = '0;
        end else if (bus.init_in) begin
            v_out_d = v_new;
            f_out_d = f_new;
            t_out_d = bus.T_in;
            init_d  = 1'b1;
            vdiag_d = bus.V_in;
            vleft_d = v_new;
            e_d     = e_new;
            col_d   = (&col_q) ? col_q : col_q + COL_W'(1);
            if (v_new > best_q) begin
                best_d = v_new;
                bcol_d = col_q;
            end
        end

        // Scores loaded here only reach the datapath on the following column.
        if (bus.cfg_we) begin
            match_d = bus.cfg_match;
            mis_d   = bus.cfg_mismatch;
            open_d  = bus.cfg_open;
            ext_d   = bus.cfg_ext;
            local_d = bus.cfg_local;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_out_q <= '0;
            f_out_q <= '0;
            t_out_q <= '0;
            init_q  <= 1'b0;
            s_q     <= '0;
            vdiag_q <= '0;
            vleft_q <= '0;
            e_q     <= NEG;
            col_q   <= '0;
            best_q  <= NEG;
            bcol_q  <= '0;
            match_q <= SCORE_W'(MATCH_RST);
            mis_q   <= SCORE_W'(MISMATCH_RST);
            open_q  <= SCORE_W'(OPEN_RST);
            ext_q   <= SCORE_W'(EXT_RST);
            local_q <= 1'b1;
        end else begin
            v_out_q <= v_out_d;
            f_out_q <= f_out_d;
            t_out_q <= t_out_d;
            init_q  <= init_d;
            s_q     <= s_d;
            vdiag_q <= vdiag_d;
            vleft_q <= vleft_d;
            e_q     <= e_d;
            col_q   <= col_d;
            best_q  <= best_d;
            bcol_q  <= bcol_d;
            match_q <= match_d;
            mis_q   <= mis_d;
            open_q  <= open_d;
            ext_q   <= ext_d;
            local_q <= local_d;
        end
    end

    assign bus.V_out      = v_out_q;
    assign bus.F_out      = f_out_q;
    assign bus.T_out      = t_out_q;
    assign bus.init_out   = init_q;
    assign bus.best_score = best_q;
    assign bus.best_col   = bcol_q;
endmodule

// File: tb/tb_sw_affine_pe.sv
// Directed bench for sw_affine_pe: an integer reference model checked every cycle,
// plus literal output sequences for the worked alignment examples.
module tb_sw_affine_pe;
    localparam int SCORE_W = 10;
    localparam int SYM_W   = 2;
    localparam int COL_W   = 16;
    localparam int NEG     = -(1 << (SCORE_W - 1));
    localparam int POS     = (1 << (SCORE_W - 1)) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sw_affine_pe_if #(.SCORE_W(SCORE_W), .SYM_W(SYM_W), .COL_W(COL_W)) bus ();

    sw_affine_pe #(.SCORE_W(SCORE_W), .SYM_W(SYM_W), .COL_W(COL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    bit started = 0;

    int vq[$];
    int fq[$];
    int tq[$];

    int refs[8] = '{0, 1, 0, 2, 0, 1, 3, 0};
    int e19[8]  = '{10, 8, 10, 8, 10, 8, 7, 10};
    int e20[8]  = '{0, 10, 8, 7, 6, 10, 8, 7};
    int e21[8]  = '{8, 8, 8, 8, 8, 8, 20, 18};
    int eglb[8] = '{-1, 0, 0, 0, 0, 0, 0, 0};
    int eloc[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int ecfg[8] = '{10, 20, 0, 0, 0, 0, 0, 0};
    int esat[8] = '{500, 511, 0, 0, 0, 0, 0, 0};
    int erst[8] = '{10, 0, 0, 0, 0, 0, 0, 0};

    // Reference model state, plain integers
    int m_v, m_f, m_t, m_init, m_s, m_vd, m_vl, m_e, m_col, m_best, m_bcol;
    int c_match, c_mis, c_open, c_ext, c_local;
    int fp, ep, sb, vp;

    function automatic int sat(input int x);
        if (x > POS) return POS;
        if (x < NEG) return NEG;
        return x;
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v = 0; m_f = 0; m_t = 0; m_init = 0; m_s = 0; m_vd = 0; m_vl = 0;
            m_e = NEG; m_col = 0; m_best = NEG; m_bcol = 0;
            c_match = 10; c_mis = -2; c_open = -2; c_ext = -1; c_local = 1;
        end else begin
            if (bus.store_S) begin
                m_s = int'(bus.S_in); m_vd = 0; m_vl = 0; m_e = NEG;
                m_col = 0; m_best = NEG; m_bcol = 0; m_init = 0;
            end else if (bus.init_in) begin
                fp = mx(sat(int'(bus.V_in) + c_open), sat(int'(bus.F_in) + c_ext));
                ep = mx(sat(m_vl + c_open), sat(m_e + c_ext));
                sb = (int'(bus.T_in) == m_s) ? c_match : c_mis;
                vp = mx(mx(sat(m_vd + sb), ep), fp);
                if (c_local != 0 && vp < 0) vp = 0;
                if (vp > m_best) begin
                    m_best = vp;
                    m_bcol = m_col;
                end
                m_v = vp; m_f = fp; m_t = int'(bus.T_in); m_init = 1;
                m_vd = int'(bus.V_in); m_vl = vp; m_e = ep;
                if (m_col < (1 << COL_W) - 1) m_col = m_col + 1;
            end else begin
                m_init = 0;
            end
            if (bus.cfg_we) begin
                c_match = int'(bus.cfg_match); c_mis = int'(bus.cfg_mismatch);
                c_open = int'(bus.cfg_open); c_ext = int'(bus.cfg_ext);
                c_local = int'(bus.cfg_local);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("init_out", int'(bus.init_out), m_init);
            chk("V_out", int'(bus.V_out), m_v);
            chk("F_out", int'(bus.F_out), m_f);
            chk("T_out", int'(bus.T_out), m_t);
            chk("best_score", int'(bus.best_score), m_best);
            chk("best_col", int'(bus.best_col), m_bcol);
            if (bus.init_out) begin
                vq.push_back(int'(bus.V_out));
                fq.push_back(int'(bus.F_out));
                tq.push_back(int'(bus.T_out));
            end
        end
    end

    task automatic ctl(input bit st, input bit in, input bit we);
        bus.store_S = st;
        bus.init_in = in;
        bus.cfg_we  = we;
    endtask

    task automatic col(input int v, input int f, input int t);
        @(negedge clk);
        bus.V_in = SCORE_W'(v); bus.F_in = SCORE_W'(f); bus.T_in = SYM_W'(t);
        ctl(0, 1, 0);
    endtask

    task automatic store(input int s);
        @(negedge clk);
        bus.S_in = SYM_W'(s);
        ctl(1, 0, 0);
    endtask

    task automatic bubble();
        @(negedge clk);
        ctl(0, 0, 0);
    endtask

    task automatic set_cfg(input int m, input int mm, input int o, input int e, input bit loc);
        bus.cfg_match = SCORE_W'(m); bus.cfg_mismatch = SCORE_W'(mm);
        bus.cfg_open = SCORE_W'(o); bus.cfg_ext = SCORE_W'(e); bus.cfg_local = loc;
    endtask

    task automatic stream(input int v, input int f, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            col(v, f, refs[i]);
            if (gaps) begin
                bubble();
                bubble();
            end
        end
        bubble();
        bubble();
    endtask

    task automatic check_seq(input string nm, input int n, input int exp[8]);
        chk({nm, "_len"}, vq.size(), n);
        for (int i = 0; i < n && i < vq.size(); i++)
            chk($sformatf("%s_v%0d", nm, i), vq[i], exp[i]);
        vq.delete(); fq.delete(); tq.delete();
    endtask

    task automatic check_ft(input string nm, input int fexp);
        chk({nm, "_flen"}, fq.size(), 8);
        for (int i = 0; i < 8 && i < fq.size(); i++) begin
            chk($sformatf("%s_f%0d", nm, i), fq[i], fexp);
            chk($sformatf("%s_t%0d", nm, i), tq[i], refs[i]);
        end
    endtask

    task automatic check_best(input string nm, input int bs, input int bc);
        chk({nm, "_best"}, int'(bus.best_score), bs);
        chk({nm, "_bcol"}, int'(bus.best_col), bc);
    endtask

    initial begin
        bus.V_in = '0; bus.F_in = '0; bus.T_in = '0; bus.S_in = '0;
        ctl(0, 0, 0);
        set_cfg(0, 0, 0, 0, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("rst_V_out", int'(bus.V_out), 0);
        chk("rst_F_out", int'(bus.F_out), 0);
        chk("rst_init_out", int'(bus.init_out), 0);
        check_best("rst", NEG, 0);
        started = 1;
        @(negedge clk);
        rst = 1'b0;

        store(0);
        stream(0, 0, 0);
        check_ft("r19", -1);
        check_best("r19", 10, 0);
        check_seq("r19", 8, e19);

        store(1);
        stream(0, 0, 0);
        check_best("r20", 10, 1);
        check_seq("r20", 8, e20);

        store(3);
        stream(10, -4, 0);
        check_ft("r21", 8);
        check_best("r21", 20, 6);
        check_seq("r21", 8, e21);

        store(0);
        stream(0, 0, 1);
        check_seq("bubbles", 8, e19);

        // Global mode loaded together with a store
        @(negedge clk);
        bus.S_in = SYM_W'(1);
        set_cfg(10, -2, -2, -1, 1'b0);
        ctl(1, 0, 1);
        col(0, 0, 0);
        bubble(); bubble();
        check_seq("global", 1, eglb);

        @(negedge clk);
        set_cfg(10, -2, -2, -1, 1'b1);
        ctl(1, 0, 1);
        col(0, 0, 0);
        bubble(); bubble();
        check_seq("local", 1, eloc);

        // Column in the same cycle as cfg_we still uses the old match score
        store(0);
        col(0, 0, 0);
        set_cfg(20, -2, -2, -1, 1'b1);
        bus.cfg_we = 1'b1;
        col(0, 0, 0);
        bubble(); bubble();
        check_seq("cfg_old", 2, ecfg);

        @(negedge clk);
        set_cfg(500, -2, -2, -1, 1'b1);
        ctl(1, 0, 1);
        col(500, 0, 0);
        col(500, 0, 0);
        bubble(); bubble();
        check_seq("sat", 2, esat);

        // store_S wins over a column in the same cycle
        @(negedge clk);
        bus.S_in = SYM_W'(0);
        bus.T_in = SYM_W'(0);
        ctl(1, 1, 0);
        bubble(); bubble();
        check_seq("store_prio", 0, eloc);
        check_best("store_prio", NEG, 0);

        col(0, 0, 0);
        col(0, 0, 1);
        #3 rst = 1'b1;
        #1;
        chk("midrst_V_out", int'(bus.V_out), 0);
        chk("midrst_F_out", int'(bus.F_out), 0);
        chk("midrst_init", int'(bus.init_out), 0);
        vq.delete(); fq.delete(); tq.delete();
        @(negedge clk);
        rst = 1'b0;
        ctl(0, 0, 0);
        bubble(); bubble();
        store(0);
        col(0, 0, 0);
        bubble(); bubble();
        check_seq("post_rst", 1, erst);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sw_affine_pe.md
SW_AFFINE_PE -- requirements
Module: sw_affine_pe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SCORE_W, 10, signed score width.
- SYM_W, 2, symbol width.
- COL_W, 16, column counter width.
- MATCH_RST, 10, match score after reset.
- MISMATCH_RST, -2, mismatch score after reset.
- OPEN_RST, -2, gap-open score after reset.
- EXT_RST, -1, gap-extend score after reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, reset; one clock; reset is asynchronous and active-high.
- V_in, in, SCORE_W, upstream V, signed.
- F_in, in, SCORE_W, upstream F, signed.
- T_in, in, SYM_W, reference symbol.
- S_in, in, SYM_W, query symbol to store.
- store_S, in, 1, load S_in and clear the row state.
- init_in, in, 1, column valid.
- cfg_we, in, 1, load the score registers.
- cfg_match, cfg_mismatch, cfg_open, cfg_ext, in, SCORE_W each, signed scores.
- cfg_local, in, 1, local (1) or global (0) mode, sampled with cfg_we.
- V_out, F_out, out, SCORE_W each, registered V and F.
- T_out, out, SYM_W, registered copy of T_in.
- init_out, out, 1, registered column valid.
- best_score, out, SCORE_W, running best V.
- best_col, out, COL_W, column index of best_score.

Function
REQ-003 All arithmetic SHALL be two's-complement signed and saturate to [-2^(SCORE_W-1), 2^(SCORE_W-1)-1]; NEG = -2^(SCORE_W-1).
REQ-004 Internal state SHALL be: S, Vdiag, Vleft, E, col, the score registers and the local-mode bit.
REQ-005 On a valid column (init_in=1, store_S=0), the block SHALL compute:
- F' = max(V_in+open, F_in+ext).
- E' = max(Vleft+open, E+ext).
- sub = (T_in==S) ? match : mismatch.
- V' = max(Vdiag+sub, E', F'), and additionally floored at 0 when in local mode.
REQ-006 On the same edge it SHALL register V_out=V', F_out=F', T_out=T_in and init_out=1, giving a latency of 1 cycle.
REQ-007 On the same edge it SHALL update Vdiag=V_in, Vleft=V', E=E' and col=col+1; col saturates at all-ones.
REQ-008 best_score/best_col SHALL update to V'/col (pre-increment value) only when V' > best_score (strict), so ties keep the earliest column.
REQ-009 When init_in=0 and store_S=0, init_out SHALL be 0 and all other outputs and state SHALL hold; bubbles between columns are legal and transparent.
REQ-010 store_S=1 SHALL load S=S_in and set Vdiag=0, Vleft=0, E=NEG, col=0, best_score=NEG, best_col=0 and init_out=0.
REQ-011 store_S SHALL take priority over init_in; a column presented in the same cycle is discarded.
REQ-012 cfg_we=1 SHALL load the score registers and the local-mode bit; the new values take effect from the next valid column.
REQ-013 A column presented in the same cycle as cfg_we SHALL use the old values.
REQ-014 cfg_we and store_S in the same cycle SHALL both take effect.
REQ-015 In global mode the 0 floor SHALL be removed; all other rules are unchanged.

Reset
REQ-016 rst=1 SHALL asynchronously set V_out, F_out, T_out, S, Vdiag and Vleft to 0, init_out to 0, E to NEG, col to 0, best_score to NEG and best_col to 0.
REQ-017 rst=1 SHALL also reset the score registers to MATCH_RST/MISMATCH_RST/OPEN_RST/EXT_RST and set local mode (1).
REQ-018 Reset mid-stream SHALL abort the row with no further init_out until new valid columns are presented.

Verification
REQ-019 Defaults, V_in=0, F_in=0, store S=A(00), reference A,C,A,G,A,C,T,A (00,01,00,10,00,01,11,00) -> V_out 10,8,10,8,10,8,7,10; F_out=-1 every column; T_out echoes the reference; best 10 at col 0.
REQ-020 Re-store S=C(01) with init_in=0, same stream -> V_out 0,10,8,7,6,10,8,7; best 10 at col 1.
REQ-021 V_in=10, F_in=-4, S=T(11), same stream -> F_out=8 every column; V_out 8,8,8,8,8,8,20,18; best 20 at col 6.
REQ-022 Global mode, S=C, V_in=0, F_in=0, one column A -> V_out=-1; local mode -> V_out=0.
REQ-023 Saturation: cfg_match=500, V_in=500, Vdiag primed by a prior column with V_in=500, S=A, T=A -> V_out=511, with no wrap.
REQ-024 Bubbles, priority and reset:
- Bubbles inserted between the columns of REQ-019 -> identical V_out sequence.
- store_S with init_in together -> column dropped, init_out=0.
- rst pulse mid-stream -> outputs 0 immediately, and score registers back at the reset defaults.
